// File: rtl/acc_result_drain.sv
// acc_result_drain: drains snapshotted core accumulators into data memory one write at a time
module acc_result_drain #(
    parameter int NUM_CORES = 8,
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 16
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic [ADDR_W-1:0]           base_addr,
    input  logic [NUM_CORES-1:0]        core_mask,
    input  logic [NUM_CORES*DATA_W-1:0] acc_in,
    input  logic                        mem_ready,
    output logic                        mem_write,
    output logic [ADDR_W-1:0]           mem_addr,
    output logic [DATA_W-1:0]           mem_data,
    output logic [NUM_CORES-1:0]        acc_clr,
    output logic                        busy,
    output logic                        done
);
    localparam int IW = NUM_CORES > 1 ? $clog2(NUM_CORES) : 1;
    typedef enum logic [1:0] {IDLE, SCAN, WRITE, FINISH} state_t;
    state_t                      state_q, state_d;
    logic [IW-1:0]               idx_q, idx_d;
    logic [NUM_CORES*DATA_W-1:0] snap_q, snap_d;
    logic [NUM_CORES-1:0]        mask_q, mask_d;
    logic [ADDR_W-1:0]           base_q, base_d;
    logic                        mem_write_q, mem_write_d;
    logic [ADDR_W-1:0]           mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]           mem_data_q, mem_data_d;
    logic [NUM_CORES-1:0]        acc_clr_q, acc_clr_d;
    logic                        busy_q, busy_d;
    logic                        done_q, done_d;
    logic                        last;
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        snap_d     = snap_q;
        mask_d     = mask_q;
        base_d     = base_q;
        mem_addr_d = mem_addr_q;
        mem_data_d = mem_data_q;
        acc_clr_d  = '0;
        last       = idx_q == IW'(NUM_CORES - 1);
        case (state_q)
            IDLE: if (start) begin
                snap_d  = acc_in;
                mask_d  = core_mask;
                base_d  = base_addr;
                idx_d   = '0;
                state_d = SCAN;
            end
            SCAN: if (mask_q[idx_q]) begin
                mem_addr_d = base_q + ADDR_W'(idx_q);
                mem_data_d = snap_q[idx_q*DATA_W +: DATA_W];
                state_d    = WRITE;
            end else begin
                idx_d   = last ? idx_q : idx_q + 1'b1;
                state_d = last ? FINISH : SCAN;
            end
            WRITE: if (mem_ready) begin
                acc_clr_d[idx_q] = 1'b1;
                idx_d            = last ? idx_q : idx_q + 1'b1;
                state_d          = last ? FINISH : SCAN;
            end
            FINISH: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        // outputs are registered copies of what the next state implies
        mem_write_d = state_d == WRITE;
        busy_d      = state_d == SCAN || state_d == WRITE;
        done_d      = state_d == FINISH;
    end
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= IDLE;
            idx_q       <= '0;
            snap_q      <= '0;
            mask_q      <= '0;
            base_q      <= '0;
            mem_write_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_data_q  <= '0;
            acc_clr_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            snap_q      <= snap_d;
            mask_q      <= mask_d;
            base_q      <= base_d;
            mem_write_q <= mem_write_d;
            mem_addr_q  <= mem_addr_d;
            mem_data_q  <= mem_data_d;
            acc_clr_q   <= acc_clr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
        end
    end
    assign mem_write = mem_write_q;
    assign mem_addr  = mem_addr_q;
    assign mem_data  = mem_data_q;
    assign acc_clr   = acc_clr_q;
    assign busy      = busy_q;
    assign done      = done_q;
endmodule

// File: tb/tb_acc_result_drain.sv
// tb_acc_result_drain: randomized drains checked against a write-list model of the drain rules
module tb_acc_result_drain;
    localparam int N = 8, DW = 16, AW = 16;
    typedef struct {int idx; logic [AW-1:0] addr; logic [DW-1:0] data;} wr_t;
    logic clk = 0, rst = 0, start = 0, mem_ready = 0;
    logic [AW-1:0] base_addr = '0;
    logic [N-1:0] core_mask = '0;
    logic [N*DW-1:0] acc_in = '0;
    logic mem_write, busy, done;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data;
    logic [N-1:0] acc_clr;
    logic [AW-1:0] last_addr = '0;
    logic [DW-1:0] last_data = '0;
    int n_chk = 0, n_fail = 0;

    acc_result_drain #(.NUM_CORES(N), .DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .rst(rst), .start(start), .base_addr(base_addr), .core_mask(core_mask),
        .acc_in(acc_in), .mem_ready(mem_ready), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_data(mem_data), .acc_clr(acc_clr), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_mem_write"}, mem_write, 0);
        check({tag, "_acc_clr"}, acc_clr, 0);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_done"}, done, 0);
    endtask

    function automatic logic [N*DW-1:0] rand_vals();
        logic [N*DW-1:0] v;
        for (int i = 0; i < N; i++) v[i*DW +: DW] = DW'($urandom);
        return v;
    endfunction

    // Starts a drain at a negedge and follows it cycle by cycle until done.
    task automatic drain(input logic [AW-1:0] base, input logic [N-1:0] mask, input logic [N*DW-1:0] vals,
                         input int stall_lo, input int stall_hi, input bit mess, input int exp_total);
        wr_t q[$];
        int exp_done = N + 1, wcnt = 0, stall = 0;
        bit done_seen = 0;
        logic [N-1:0] clr_exp = '0;
        for (int i = 0; i < N; i++)
            if (mask[i]) q.push_back('{i, base + AW'(i), vals[i*DW +: DW]});
        base_addr = base;
        core_mask = mask;
        acc_in = vals;
        start = 1;
        @(negedge clk);
        start = 0;
        for (int c = 1; c < 300 && !done_seen; c++) begin
            check("acc_clr", acc_clr, clr_exp);
            clr_exp = '0;
            start = 0;
            if (mess && (c == 3 || c == 6)) begin
                acc_in = rand_vals();
                base_addr = AW'($urandom);
                core_mask = N'($urandom);
                start = 1;
            end
            if (done) begin
                done_seen = 1;
                mem_ready = 0;
                check("done_cycle", c, exp_done);
                if (exp_total > 0) check("done_latency", c, exp_total);
                check("busy_at_done", busy, 0);
                check("write_at_done", mem_write, 0);
                check("writes_left", q.size(), 0);
                check("addr_hold", mem_addr, last_addr);
                check("data_hold", mem_data, last_data);
            end else begin
                check("busy", busy, 1);
                if (mem_write) begin
                    if (q.size() == 0) check("extra_write", mem_write, 0);
                    else begin
                        if (wcnt == 0) stall = $urandom_range(stall_hi, stall_lo);
                        check("addr", mem_addr, q[0].addr);
                        check("data", mem_data, q[0].data);
                        mem_ready = wcnt >= stall;
                        wcnt++;
                        if (mem_ready) begin
                            clr_exp = N'(1) << q[0].idx;
                            last_addr = q[0].addr;
                            last_data = q[0].data;
                            exp_done += wcnt;
                            wcnt = 0;
                            void'(q.pop_front());
                        end
                    end
                end else mem_ready = 1'($urandom_range(1, 0));
            end
            @(negedge clk);
        end
        if (!done_seen) check("done_timeout", 0, 1);
        start = 0;
        mem_ready = 0;
        for (int k = 0; k < 4; k++) begin
            check_quiet("post_done");
            @(negedge clk);
        end
    endtask

    initial begin
        logic [N*DW-1:0] v;
        rst = 0;
        repeat (2) @(negedge clk);
        check("rst_addr", mem_addr, 0);
        check("rst_data", mem_data, 0);
        check_quiet("rst");
        rst = 1;
        for (int k = 0; k < 3; k++) begin
            mem_ready = 1'($urandom_range(1, 0));
            @(negedge clk);
            check_quiet("idle");
            check("idle_addr", mem_addr, 0);
        end
        for (int i = 0; i < N; i++) v[i*DW +: DW] = DW'(16'h0100 + i);
        drain(16'h0040, 8'hFF, v, 0, 0, 0, 17);
        drain(16'h0010, 8'b1000_0101, rand_vals(), 3, 3, 0, N + 3*4 + 1);
        drain(16'hFFFE, 8'h0F, rand_vals(), 0, 2, 1, 0);
        drain(AW'($urandom), 8'h00, rand_vals(), 0, 0, 0, 9);
        base_addr = 16'h1234;
        core_mask = 8'hFF;
        acc_in = rand_vals();
        mem_ready = 0;
        start = 1;
        @(negedge clk);
        start = 0;
        for (int k = 0; k < 10 && !mem_write; k++) @(negedge clk);
        check("rst_setup_write", mem_write, 1);
        rst = 0;
        @(negedge clk);
        rst = 1;
        check("midrst_addr", mem_addr, 0);
        check("midrst_data", mem_data, 0);
        check_quiet("midrst");
        @(negedge clk);
        check_quiet("after_rst");
        last_addr = '0;
        last_data = '0;
        drain(16'h0800, 8'hFF, rand_vals(), 0, 2, 0, 0);
        for (int r = 0; r < 6; r++)
            drain(AW'($urandom), N'($urandom), rand_vals(), 0, 3, r[0], 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
